// File: rtl/pwm_fader_pkg.sv
// Shared types for the PWM fader: configuration mode encoding, channel FSM
// states and a small index-width helper used for port sizing.
package pwm_fader_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_STATIC  = 2'd1,
      MODE_FADE    = 2'd2,
      MODE_BREATHE = 2'd3
   } fade_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2
   } chan_state_e;

   // Bits needed to index n items, never fewer than one.
   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: mode FSM driving a working duty, a period-aligned active
// duty, and the registered PWM comparator against the shared period counter.
module pwm_channel
   import pwm_fader_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  fade_mode_e       cfg_mode,
   input  logic [WIDTH-1:0] cfg_level,
   input  logic             tick,
   input  logic             period_end,
   input  logic [WIDTH-1:0] cnt,
   output logic             led,
   output logic             busy
);

   chan_state_e      state_r, state_s;
   logic [WIDTH-1:0] duty_work_r, duty_work_s;
   logic [WIDTH-1:0] target_r, target_s;
   logic             breathe_r, breathe_s;
   logic [WIDTH-1:0] floor_s;
   logic [WIDTH-1:0] duty_active_r;
   logic             led_r;

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      if (v == {WIDTH{1'b1}}) begin
         return v;
      end else begin
         return v + WIDTH'(1);
      end
   endfunction

   function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
      if (v == {WIDTH{1'b0}}) begin
         return v;
      end else begin
         return v - WIDTH'(1);
      end
   endfunction

   // Next-state logic: a configuration write always takes precedence over a step tick.
   always_comb begin
      state_s     = state_r;
      duty_work_s = duty_work_r;
      target_s    = target_r;
      breathe_s   = breathe_r;
      floor_s     = breathe_r ? {WIDTH{1'b0}} : target_r;
      if (cfg_wr) begin
         case (cfg_mode)
            MODE_OFF: begin
               duty_work_s = {WIDTH{1'b0}};
               target_s    = {WIDTH{1'b0}};
               breathe_s   = 1'b0;
               state_s     = ST_IDLE;
            end
            MODE_STATIC: begin
               duty_work_s = cfg_level;
               target_s    = cfg_level;
               breathe_s   = 1'b0;
               state_s     = ST_IDLE;
            end
            MODE_FADE: begin
               target_s  = cfg_level;
               breathe_s = 1'b0;
               if (cfg_level > duty_work_r) begin
                  state_s = ST_RAMP_UP;
               end else if (cfg_level < duty_work_r) begin
                  state_s = ST_RAMP_DOWN;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            MODE_BREATHE: begin
               if (cfg_level == {WIDTH{1'b0}}) begin
                  duty_work_s = {WIDTH{1'b0}};
                  target_s    = {WIDTH{1'b0}};
                  breathe_s   = 1'b0;
                  state_s     = ST_IDLE;
               end else begin
                  target_s  = cfg_level;
                  breathe_s = 1'b1;
                  state_s   = (duty_work_r < cfg_level) ? ST_RAMP_UP : ST_RAMP_DOWN;
               end
            end
            default: begin
               duty_work_s = {WIDTH{1'b0}};
               breathe_s   = 1'b0;
               state_s     = ST_IDLE;
            end
         endcase
      end else if (tick) begin
         case (state_r)
            ST_RAMP_UP: begin
               if (duty_work_r < target_r) begin
                  duty_work_s = sat_inc(duty_work_r);
               end else begin
                  duty_work_s = duty_work_r;
               end
               if (duty_work_s >= target_r) begin
                  state_s = breathe_r ? ST_RAMP_DOWN : ST_IDLE;
               end else begin
                  state_s = ST_RAMP_UP;
               end
            end
            // Breathing descends to zero; a plain fade stops at its target.
            ST_RAMP_DOWN: begin
               if (duty_work_r > floor_s) begin
                  duty_work_s = sat_dec(duty_work_r);
               end else begin
                  duty_work_s = duty_work_r;
               end
               if (duty_work_s <= floor_s) begin
                  state_s = breathe_r ? ST_RAMP_UP : ST_IDLE;
               end else begin
                  state_s = ST_RAMP_DOWN;
               end
            end
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Channel state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         duty_work_r <= {WIDTH{1'b0}};
         target_r    <= {WIDTH{1'b0}};
         breathe_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         duty_work_r <= duty_work_s;
         target_r    <= target_s;
         breathe_r   <= breathe_s;
      end
   end

   // Active duty changes only at the period wrap so a PWM period is never cut short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_active_r <= {WIDTH{1'b0}};
         led_r         <= 1'b0;
      end else begin
         if (period_end) begin
            duty_active_r <= duty_work_r;
         end else begin
            duty_active_r <= duty_active_r;
         end
         led_r <= (cnt < duty_active_r);
      end
   end

   assign led  = led_r;
   assign busy = (state_r != ST_IDLE);

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel LED PWM fader: shared period counter and fade prescaler,
// single-entry configuration handshake, one pwm_channel per LED.
module pwm_fader
   import pwm_fader_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [idx_width(CHANNELS)-1:0]   cfg_chan,
   input  logic [1:0]                       cfg_mode,
   input  logic [WIDTH-1:0]                 cfg_level,
   output logic [CHANNELS-1:0]              led,
   output logic                             busy
);

   localparam int PRE_W = idx_width(PRESCALE);

   logic [WIDTH-1:0]    cnt_r;
   logic [PRE_W-1:0]    pre_r;
   logic                cfg_ready_r;
   logic                tick_s;
   logic                period_end_s;
   logic                xfer_s;
   logic [CHANNELS-1:0] wr_s;
   logic [CHANNELS-1:0] led_s;
   logic [CHANNELS-1:0] busy_s;

   assign tick_s       = (pre_r == PRE_W'(PRESCALE - 1));
   assign period_end_s = (cnt_r == {WIDTH{1'b1}});
   assign xfer_s       = cfg_valid && cfg_ready_r;

   // Free-running PWM period counter shared by every channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {WIDTH{1'b0}};
      end else begin
         cnt_r <= cnt_r + WIDTH'(1);
      end
   end

   // Fade-step prescaler; tick_s marks its last count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_r <= {PRE_W{1'b0}};
      end else if (tick_s) begin
         pre_r <= {PRE_W{1'b0}};
      end else begin
         pre_r <= pre_r + PRE_W'(1);
      end
   end

   // Ready drops for exactly the cycle after each accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_ready_r <= 1'b0;
      end else begin
         cfg_ready_r <= !xfer_s;
      end
   end

   // Decode the write strobe; out-of-range channel indices select nobody.
   always_comb begin
      wr_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         if (xfer_s && (int'(cfg_chan) == i)) begin
            wr_s[i] = 1'b1;
         end else begin
            wr_s[i] = 1'b0;
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      pwm_channel #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .cfg_wr    (wr_s[i]),
         .cfg_mode  (fade_mode_e'(cfg_mode)),
         .cfg_level (cfg_level),
         .tick      (tick_s),
         .period_end(period_end_s),
         .cnt       (cnt_r),
         .led       (led_s[i]),
         .busy      (busy_s[i])
      );
   end

   assign cfg_ready = cfg_ready_r;
   assign led       = led_s;
   assign busy      = |busy_s;

endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader with a per-cycle behavioural model of duty,
// ramps, handshake and PWM outputs, plus hand-computed literal checks.
module tb_pwm_fader;

   localparam int CHANNELS = 3;
   localparam int WIDTH    = 8;
   localparam int PRESCALE = 4;
   localparam int PERIOD   = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_chan = 2'd0;
   logic [1:0] cfg_mode = 2'd0;
   logic [7:0] cfg_level = 8'd0;
   logic [2:0] led;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state (dir: +1 rising, -1 falling, 0 settled).
   int m_cnt = 0;
   int m_pre = 0;
   int m_ready = 0;
   int m_work[CHANNELS];
   int m_tgt[CHANNELS];
   int m_act[CHANNELS];
   int m_dir[CHANNELS];
   int m_breathe[CHANNELS];
   int m_led[CHANNELS];
   int tick_seq[$];
   int rec_ch2 = 0;

   always #5 clk = ~clk;

   pwm_fader #(
      .CHANNELS(CHANNELS),
      .WIDTH   (WIDTH),
      .PRESCALE(PRESCALE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_chan (cfg_chan),
      .cfg_mode (cfg_mode),
      .cfg_level(cfg_level),
      .led      (led),
      .busy     (busy)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_pre   = 0;
      m_ready = 0;
      for (int c = 0; c < CHANNELS; c++) begin
         m_work[c] = 0; m_tgt[c] = 0; m_act[c] = 0;
         m_dir[c] = 0; m_breathe[c] = 0; m_led[c] = 0;
      end
   endtask

   task automatic model_apply(input int c, input int mode, input int lvl);
      case (mode)
         0: begin m_work[c] = 0; m_dir[c] = 0; m_breathe[c] = 0; end
         1: begin m_work[c] = lvl; m_dir[c] = 0; m_breathe[c] = 0; end
         2: begin
            m_tgt[c] = lvl; m_breathe[c] = 0;
            m_dir[c] = (lvl > m_work[c]) ? 1 : ((lvl < m_work[c]) ? -1 : 0);
         end
         default: begin
            if (lvl == 0) begin
               m_work[c] = 0; m_dir[c] = 0; m_breathe[c] = 0;
            end else begin
               m_tgt[c] = lvl; m_breathe[c] = 1;
               m_dir[c] = (m_work[c] < lvl) ? 1 : -1;
            end
         end
      endcase
   endtask

   // Advance the model by one rising edge using the inputs present at that edge.
   task automatic model_step();
      int tick;
      int xfer;
      if (rst) begin
         model_reset();
         return;
      end
      tick = (m_pre == PRESCALE - 1) ? 1 : 0;
      xfer = (cfg_valid && (m_ready != 0)) ? 1 : 0;
      for (int c = 0; c < CHANNELS; c++) begin
         m_led[c] = (m_cnt < m_act[c]) ? 1 : 0;
         if (m_cnt == PERIOD - 1) m_act[c] = m_work[c];
         if (xfer != 0 && int'(cfg_chan) == c) begin
            model_apply(c, int'(cfg_mode), int'(cfg_level));
         end else if (tick != 0 && m_dir[c] != 0) begin
            m_work[c] = m_work[c] + m_dir[c];
            if (m_work[c] < 0) m_work[c] = 0;
            if (m_work[c] > PERIOD - 1) m_work[c] = PERIOD - 1;
            if (m_breathe[c] != 0) begin
               if (m_dir[c] > 0 && m_work[c] >= m_tgt[c]) m_dir[c] = -1;
               else if (m_dir[c] < 0 && m_work[c] <= 0) m_dir[c] = 1;
            end else if (m_work[c] == m_tgt[c]) begin
               m_dir[c] = 0;
            end
            if (c == 2 && rec_ch2 != 0) tick_seq.push_back(m_work[c]);
         end
      end
      m_ready = (xfer != 0) ? 0 : 1;
      m_pre   = (m_pre + 1) % PRESCALE;
      m_cnt   = (m_cnt + 1) % PERIOD;
   endtask

   task automatic compare_all();
      int exp_led;
      int exp_busy;
      exp_led  = m_led[0] | (m_led[1] << 1) | (m_led[2] << 2);
      exp_busy = (m_dir[0] != 0 || m_dir[1] != 0 || m_dir[2] != 0) ? 1 : 0;
      check("led", int'(led), exp_led);
      check("cfg_ready", int'(cfg_ready), m_ready);
      check("busy", int'(busy), exp_busy);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic xfer(input int ch, input int mode, input int lvl);
      int acc;
      int n;
      acc = 0;
      n   = 0;
      cfg_chan  = 2'(ch);
      cfg_mode  = 2'(mode);
      cfg_level = 8'(lvl);
      cfg_valid = 1'b1;
      while (acc == 0 && n < 4) begin
         acc = m_ready;
         cycle();
         n++;
      end
      cfg_valid = 1'b0;
      check("xfer_accepted", acc, 1);
   endtask

   task automatic count_high(input int ch, output int hits);
      hits = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycle();
         hits += int'(led[ch]);
      end
   endtask

   initial begin
      int hits;
      int n;
      int exp_seq[8];
      exp_seq = '{1, 2, 3, 2, 1, 0, 1, 2};
      model_reset();

      // Reset held for ten cycles.
      rst = 1'b1;
      run(10);
      check("rst_led", int'(led), 0);
      check("rst_ready", int'(cfg_ready), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      cycle();
      check("ready_after_release", int'(cfg_ready), 1);

      // Static duty levels on channel 0.
      xfer(0, 1, 64);
      run(520);
      count_high(0, hits);
      check("static64_high", hits, 64);
      xfer(0, 1, 0);
      run(520);
      count_high(0, hits);
      check("static0_high", hits, 0);
      xfer(0, 1, 255);
      run(520);
      count_high(0, hits);
      check("static255_high", hits, 255);
      check("model_static_act", m_act[0], 255);

      // Fade channel 1 from 0 to 10: ten ticks of four clocks each.
      xfer(1, 2, 10);
      check("fade_busy", int'(busy), 1);
      n = 0;
      while (busy && n < 100) begin
         cycle();
         n++;
      end
      check("fade_duration_37_to_40", (n >= 37 && n <= 40) ? 1 : 0, 1);
      check("model_fade_work", m_work[1], 10);
      check("model_fade_dir", m_dir[1], 0);
      run(520);
      count_high(1, hits);
      check("fade10_high", hits, 10);

      // Breathe channel 2 with peak 3.
      rec_ch2 = 1;
      xfer(2, 3, 3);
      check("breathe_busy_start", int'(busy), 1);
      run(40);
      rec_ch2 = 0;
      check("breathe_busy_end", int'(busy), 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("breathe_seq%0d", i), (i < tick_seq.size()) ? tick_seq[i] : -1, exp_seq[i]);
      end
      xfer(2, 0, 0);
      run(520);
      count_high(2, hits);
      check("breathe_off_high", hits, 0);
      check("breathe_off_busy", int'(busy), 0);

      // Out-of-range channel: accepted, ignored, ready low for one cycle only.
      xfer(3, 1, 77);
      check("badchan_ready_low", int'(cfg_ready), 0);
      cycle();
      check("badchan_ready_back", int'(cfg_ready), 1);
      check("badchan_busy", int'(busy), 0);
      count_high(0, hits);
      check("badchan_ch0_unchanged", hits, 255);

      // Reset in the middle of a long fade.
      xfer(1, 2, 200);
      run(50);
      check("ramp_busy_before_rst", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_led", int'(led), 0);
      check("async_rst_ready", int'(cfg_ready), 0);
      check("async_rst_busy", int'(busy), 0);
      run(3);
      rst = 1'b0;
      cycle();
      check("ready_after_mid_rst", int'(cfg_ready), 1);
      run(600);
      check("no_ramp_after_rst", int'(busy), 0);
      count_high(1, hits);
      check("ch1_dark_after_rst", hits, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
